// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words and writes them
// to consecutive instruction-memory addresses, holding the core busy meanwhile.
module instruction_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   Length,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [31:0]           WriteData,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            bcount_q, bcount_d;
  logic [23:0]           shift_q, shift_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   wcount_inc;

  assign wcount_inc = wcount_q + (ADDR_WIDTH+1)'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcount_d = wcount_q;
    addr_d   = addr_q;
    bcount_d = bcount_q;
    shift_d  = shift_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          len_d    = (Length > DEPTH_W) ? DEPTH_W : Length;
          addr_d   = '0;
          wcount_d = '0;
          bcount_d = '0;
          state_d  = (Length == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        // ByteReady is exactly "state is COLLECT", so ByteValid alone completes the handshake
        if (ByteValid) begin
          shift_d  = {shift_q[15:0], ByteIn};
          bcount_d = bcount_q + 2'd1;
          if (bcount_q == 2'd3) begin
            wdata_d = {shift_q, ByteIn};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d   = addr_q + ADDR_WIDTH'(1);
        wcount_d = wcount_inc;
        state_d  = (wcount_inc == len_q) ? S_DONE : S_COLLECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_COLLECT);
    we_d    = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wcount_q <= '0;
      addr_q   <= '0;
      bcount_q <= '0;
      shift_q  <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wcount_q <= wcount_d;
      addr_q   <= addr_d;
      bcount_q <= bcount_d;
      shift_q  <= shift_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ByteReady    = ready_q;
  assign WriteEnable  = we_q;
  assign WriteAddress = addr_q;
  assign WriteData    = wdata_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that writes a program into the writable instruction memory ahead of execution. It accepts a byte stream on a valid/ready handshake and assembles big-endian 32-bit instruction words. Each complete word is written to consecutive word addresses starting at 0, and the block signals completion. It sits between the host/debug byte link and the instruction memory write port, and holds the core in reset while loading.

## Interface
- ADDR_WIDTH, 6, word-address width of instruction memory
- DEPTH, 64, number of instruction words (2**ADDR_WIDTH)
- Clk  input  1  single clock, all state on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  begin a load session; sampled only in IDLE
- Length  input  ADDR_WIDTH+1  words to load; captured on accepted Start
- ByteIn  input  8  stream byte
- ByteValid  input  1  ByteIn valid
- ByteReady  output  1  loader can accept a byte this cycle
- WriteEnable  output  1  instruction memory write strobe
- WriteAddress  output  ADDR_WIDTH  word address being written
- WriteData  output  32  assembled instruction word
- Busy  output  1  session in progress; drives core reset hold
- Done  output  1  one-cycle pulse at end of session

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: ByteReady=0, Busy=0. Start=1 at an edge moves to COLLECT. That edge also captures Length, clamped to DEPTH if larger, and clears the address, word count and byte count.
  - If the captured Length is 0, go to DONE instead; no writes occur.
- COLLECT: ByteReady=1, Busy=1. A byte is accepted on an edge where ByteValid && ByteReady.
  - Byte order is big-endian: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - Accepting byte 3 latches the full word into the WriteData register and moves to WRITE.
- WRITE: single cycle. WriteEnable=1, ByteReady=0.
  - WriteAddress holds the current address and WriteData the assembled word.
  - At the closing edge the address and word count increment. If word count+1 == Length, go to DONE; otherwise go to COLLECT.
- DONE: single cycle. Done=1, Busy=1, ByteReady=0. Then go to IDLE.
- Start is ignored outside IDLE. A byte offered outside COLLECT is not accepted; ByteReady=0 there, so the source must hold it.
- Address width rule: the address increments modulo DEPTH. A Length==DEPTH session ends in DONE after writing address DEPTH-1, so the wrapped value 0 is never written.
- Reset during any state: immediate return to IDLE, partial word discarded, no further writes. Instruction memory contents already written are retained.
- A session does not time out. An incomplete stream leaves the block in COLLECT until Reset.

## Timing
- Reset values: ByteReady=0, WriteEnable=0, WriteAddress=0, WriteData=0, Busy=0, Done=0. Internal counters are 0 and the state is IDLE.
- Start edge E: Busy=1 and ByteReady=1 from E onward (COLLECT).
- Fourth byte accepted at edge N: WriteEnable=1 for the cycle between N and N+1; ByteReady=1 again after N+1.
- Peak throughput: 1 word per 5 cycles with ByteValid held high.
- The last write's closing edge M starts DONE: Done=1 between M and M+1. Busy=0 after M+1.
- Length 0: DONE is the cycle directly after the Start edge.
- All outputs are registered or decoded from the state register only. There is no combinational path from ByteValid to ByteReady.

## Test plan
- Reset check: assert Reset asynchronously mid-cycle -> all outputs 0 immediately, state IDLE. Release, pulse Start with Length=0 -> Done pulse on the next cycle, no WriteEnable.
- Back-to-back load: Length=4, stream bytes 01 2A 40 20 02 53 88 22 00 A6 20 24 01 9D 58 25 with ByteValid held high.
  - Writes 012A4020@0, 02538822@1, 00A62024@2, 019D5825@3.
  - Each write lands 1 cycle after its 4th byte, with 5-cycle spacing.
  - Done occurs 1 cycle after the last write; Busy falls next.
- Gapped stream: same data with random ByteValid gaps and Start pulses mid-session -> identical writes, Start ignored, no extra writes.
- Full depth: Length=64 (and again with Length=100, clamped) -> 64 writes at addresses 0..63, Done after address 63, no write to address 0 after wrap.
- Reset mid-operation: Length=4, assert Reset after 6 bytes -> exactly one write (word at address 0), none after. Then a new session writes from address 0 again.
